// File: rtl/tt_sweep_pkg.sv
// Shared types and constants for the truth-table sweep checker.
// Optional macro TT_SWEEP_ERRCNT_EN (see tt_sweep_checker) uses count_ones from here.
package tt_sweep_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_SAMPLE,
        ST_FINISH
    } sweep_state_t;

    localparam int NUM_VECTORS = 8;
    localparam int SETTLE_W = 4;
    localparam logic [NUM_VECTORS-1:0] DEFAULT_EXPECTED = 8'h45;

    // Scanning from the top down leaves the lowest set index as the final winner.
    function automatic logic [2:0] lowest_set(input logic [NUM_VECTORS-1:0] v);
        lowest_set = 3'd0;
        for (int i = NUM_VECTORS - 1; i >= 0; i--) begin
            if (v[i]) begin
                lowest_set = 3'(i);
            end
        end
    endfunction

    function automatic logic [3:0] count_ones(input logic [NUM_VECTORS-1:0] v);
        count_ones = 4'd0;
        for (int i = 0; i < NUM_VECTORS; i++) begin
            count_ones = count_ones + {3'b000, v[i]};
        end
    endfunction

endpackage

// File: rtl/tt_settle_timer.sv
// Loadable down-counter that flags the last settle cycle of each vector.
module tt_settle_timer
    import tt_sweep_pkg::*;
#(
    parameter int unsigned LOAD_VALUE = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    output logic expire
);

    logic [SETTLE_W-1:0] count;

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= SETTLE_W'(LOAD_VALUE);
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    // Loaded on entry to SETTLE, so a count of one marks the final settle cycle.
    assign expire = (count == SETTLE_W'(1));

endmodule

// File: rtl/tt_sweep_checker.sv
// Sweeps abc through all eight input vectors, samples f and compares with EXPECTED.
// Define TT_SWEEP_ERRCNT_EN to add the err_cnt mismatch-count output.
module tt_sweep_checker
    import tt_sweep_pkg::*;
#(
    parameter int unsigned SETTLE = 1,
    parameter logic [NUM_VECTORS-1:0] EXPECTED = DEFAULT_EXPECTED
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   abort,
    input  logic                   f,
    output logic [2:0]             abc,
    output logic                   busy,
    output logic                   done,
    output logic [NUM_VECTORS-1:0] captured,
    output logic                   pass,
    output logic [2:0]             fail_idx
`ifdef TT_SWEEP_ERRCNT_EN
    ,
    output logic [3:0]             err_cnt
`endif
);

    localparam logic [2:0] LAST_VECTOR = 3'(NUM_VECTORS - 1);

    sweep_state_t state, next_state;
    logic [2:0] idx;
    logic load, expire, accept, sample, abort_hit;
    logic [NUM_VECTORS-1:0] cap_final, mismatch;

    tt_settle_timer #(.LOAD_VALUE(SETTLE)) u_timer (
        .clk    (clk),
        .rst    (rst),
        .load   (load),
        .expire (expire)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Abort is checked ahead of every other transition so it also beats the final sample.
    always_comb begin
        next_state = state;
        load       = 1'b0;
        accept     = 1'b0;
        sample     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start && !abort) begin
                    next_state = ST_SETTLE;
                    load       = 1'b1;
                    accept     = 1'b1;
                end
            end
            ST_SETTLE: begin
                if (abort) begin
                    next_state = ST_IDLE;
                end else if (expire) begin
                    next_state = ST_SAMPLE;
                end
            end
            ST_SAMPLE: begin
                if (abort) begin
                    next_state = ST_IDLE;
                end else begin
                    sample = 1'b1;
                    if (idx == LAST_VECTOR) begin
                        next_state = ST_FINISH;
                    end else begin
                        next_state = ST_SETTLE;
                        load       = 1'b1;
                    end
                end
            end
            ST_FINISH: begin
                next_state = ST_IDLE;
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

    assign busy      = (state == ST_SETTLE) || (state == ST_SAMPLE);
    assign done      = (state == ST_FINISH);
    assign abc       = busy ? idx : 3'b000;
    assign abort_hit = busy && abort;

    // The verdict is taken on the final sample edge, so bit 7 comes straight from f.
    assign cap_final = {f, captured[NUM_VECTORS-2:0]};
    assign mismatch  = cap_final ^ EXPECTED;

    always_ff @(posedge clk) begin
        if (rst) begin
            idx      <= 3'd0;
            captured <= '0;
            pass     <= 1'b0;
            fail_idx <= 3'd0;
        end else if (accept) begin
            idx      <= 3'd0;
            captured <= '0;
            pass     <= 1'b0;
            fail_idx <= 3'd0;
        end else if (abort_hit) begin
            idx <= 3'd0;
        end else if (sample) begin
            captured[idx] <= f;
            if (idx == LAST_VECTOR) begin
                idx      <= 3'd0;
                pass     <= (cap_final == EXPECTED);
                fail_idx <= lowest_set(mismatch);
            end else begin
                idx <= idx + 3'd1;
            end
        end
    end

`ifdef TT_SWEEP_ERRCNT_EN
    always_ff @(posedge clk) begin
        if (rst || accept) begin
            err_cnt <= 4'd0;
        end else if (sample && (idx == LAST_VECTOR)) begin
            err_cnt <= count_ones(mismatch);
        end
    end
`else
    // Without the counter, pass and fail_idx are the only sweep summary.
`endif

endmodule

// File: tb/tb_tt_sweep_checker.sv
// Self-checking bench: two checkers (SETTLE=1 and SETTLE=3) against a time-based reference model.
module tb_tt_sweep_checker;

    localparam logic [7:0] GOLDEN = 8'h45;

    logic       clk = 1'b0;
    int         cyc = 0;
    int         n_cmp = 0;
    int         n_bad = 0;
    bit         chk_en = 1'b0;

    logic [1:0] rst_v, start_v, abort_v, f_v, busy_v, done_v, pass_v;
    logic [7:0] tt_v[2];
    logic [2:0] abc_v[2];
    logic [7:0] cap_v[2];
    logic [2:0] fidx_v[2];
    logic [3:0] err_v[2];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign f_v[0] = tt_v[0][abc_v[0]];
    assign f_v[1] = tt_v[1][abc_v[1]];

    tt_sweep_checker #(.SETTLE(1), .EXPECTED(GOLDEN)) dut1 (
        .clk(clk), .rst(rst_v[0]), .start(start_v[0]), .abort(abort_v[0]), .f(f_v[0]),
        .abc(abc_v[0]), .busy(busy_v[0]), .done(done_v[0]), .captured(cap_v[0]),
        .pass(pass_v[0]), .fail_idx(fidx_v[0])
`ifdef TT_SWEEP_ERRCNT_EN
        , .err_cnt(err_v[0])
`endif
    );

    tt_sweep_checker #(.SETTLE(3), .EXPECTED(GOLDEN)) dut3 (
        .clk(clk), .rst(rst_v[1]), .start(start_v[1]), .abort(abort_v[1]), .f(f_v[1]),
        .abc(abc_v[1]), .busy(busy_v[1]), .done(done_v[1]), .captured(cap_v[1]),
        .pass(pass_v[1]), .fail_idx(fidx_v[1])
`ifdef TT_SWEEP_ERRCNT_EN
        , .err_cnt(err_v[1])
`endif
    );

`ifndef TT_SWEEP_ERRCNT_EN
    assign err_v[0] = 4'd0;
    assign err_v[1] = 4'd0;
`endif

    // Reference model: tracks elapsed cycles since the accepted start, not FSM states.
    typedef struct {
        bit         run;
        int         el;
        logic [7:0] cap;
        bit         pass;
        bit         done;
        logic [2:0] fidx;
        logic [3:0] err;
    } model_t;

    model_t mdl[2];

    function automatic int settle_of(input int i);
        return (i == 0) ? 1 : 3;
    endfunction

    function automatic logic [2:0] first_diff(input logic [7:0] v);
        for (int i = 0; i < 8; i++) begin
            if (v[i]) return 3'(i);
        end
        return 3'd0;
    endfunction

    function automatic model_t step(input model_t m, input int s, input bit r,
                                    input bit st, input bit ab, input logic [7:0] tt);
        model_t n;
        int k;
        n = m;
        n.done = 1'b0;
        if (r) begin
            n.run = 0; n.el = 0; n.cap = 8'h00; n.pass = 0; n.fidx = 3'd0; n.err = 4'd0;
        end else if (m.run) begin
            if (ab) begin
                n.run = 0;
            end else begin
                if ((m.el + 1) % (s + 1) == 0) begin
                    k = m.el / (s + 1);
                    n.cap[k] = tt[k];
                    if (k == 7) begin
                        n.run  = 0;
                        n.done = 1;
                        n.pass = (n.cap == GOLDEN);
                        n.fidx = first_diff(n.cap ^ GOLDEN);
                        n.err  = 4'($countones(n.cap ^ GOLDEN));
                    end
                end
                n.el = m.el + 1;
            end
        end else if (!m.done && st && !ab) begin
            n.run = 1; n.el = 0; n.cap = 8'h00; n.pass = 0; n.fidx = 3'd0; n.err = 4'd0;
        end
        return n;
    endfunction

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            mdl[i] <= step(mdl[i], settle_of(i), rst_v[i], start_v[i], abort_v[i], tt_v[i]);
        end
    end

    task automatic checkOutput(input string name, input int inst,
                               input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("[TB] FAIL %s inst%0d cycle %0d: got %0h, required %0h", name, inst, cyc, act, exp);
        end
    endtask

    task automatic applyStimulus(input int inst, input bit r, input bit st, input bit ab);
        @(negedge clk);
        rst_v[inst]   = r;
        start_v[inst] = st;
        abort_v[inst] = ab;
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < 2; i++) begin
                checkOutput("model_busy", i, 32'(busy_v[i]), 32'(mdl[i].run));
                checkOutput("model_done", i, 32'(done_v[i]), 32'(mdl[i].done));
                checkOutput("model_abc", i, 32'(abc_v[i]),
                            mdl[i].run ? 32'(mdl[i].el / (settle_of(i) + 1)) : 32'd0);
                checkOutput("model_captured", i, 32'(cap_v[i]), 32'(mdl[i].cap));
                checkOutput("model_pass", i, 32'(pass_v[i]), 32'(mdl[i].pass));
                checkOutput("model_fail_idx", i, 32'(fidx_v[i]), 32'(mdl[i].fidx));
`ifdef TT_SWEEP_ERRCNT_EN
                checkOutput("model_err_cnt", i, 32'(err_v[i]), 32'(mdl[i].err));
`endif
            end
        end
    end

    typedef struct {
        int         inst;
        logic [7:0] tt;
        int         lat;
        logic [7:0] cap;
        bit         pass;
        logic [2:0] fidx;
        logic [3:0] err;
    } vec_t;

    task automatic run_sweep(input vec_t v);
        int  i;
        int  t0;
        bit  seen;
        i = v.inst;
        tt_v[i] = v.tt;
        applyStimulus(i, 0, 1, 0);
        t0 = cyc;
        applyStimulus(i, 0, 0, 0);
        checkOutput("first_busy", i, 32'(busy_v[i]), 32'd1);
        checkOutput("first_abc", i, 32'(abc_v[i]), 32'd0);
        checkOutput("first_captured", i, 32'(cap_v[i]), 32'd0);
        checkOutput("first_pass", i, 32'(pass_v[i]), 32'd0);
        seen = 0;
        for (int c = 0; c < 200 && !seen; c++) begin
            if (done_v[i]) seen = 1;
            else @(negedge clk);
        end
        checkOutput("done_seen", i, 32'(seen), 32'd1);
        checkOutput("done_latency", i, 32'(cyc - t0), 32'(v.lat));
        checkOutput("done_busy", i, 32'(busy_v[i]), 32'd0);
        checkOutput("sweep_captured", i, 32'(cap_v[i]), 32'(v.cap));
        checkOutput("sweep_pass", i, 32'(pass_v[i]), 32'(v.pass));
        checkOutput("sweep_fail_idx", i, 32'(fidx_v[i]), 32'(v.fidx));
`ifdef TT_SWEEP_ERRCNT_EN
        checkOutput("sweep_err_cnt", i, 32'(err_v[i]), 32'(v.err));
`endif
        applyStimulus(i, 0, 0, 0);
        checkOutput("pass_held", i, 32'(pass_v[i]), 32'(v.pass));
    endtask

    initial begin
        vec_t vecs[8];
        int   t0;
        bit   saw_done;

        vecs[0] = '{0, 8'h45, 17, 8'h45, 1, 3'd0, 4'd0};
        vecs[1] = '{0, 8'h00, 17, 8'h00, 0, 3'd0, 4'd3};
        vecs[2] = '{0, 8'h05, 17, 8'h05, 0, 3'd6, 4'd1};
        vecs[3] = '{0, 8'hFF, 17, 8'hFF, 0, 3'd1, 4'd5};
        vecs[4] = '{0, 8'h44, 17, 8'h44, 0, 3'd0, 4'd1};
        vecs[5] = '{0, 8'hC5, 17, 8'hC5, 0, 3'd7, 4'd1};
        vecs[6] = '{1, 8'h45, 33, 8'h45, 1, 3'd0, 4'd0};
        vecs[7] = '{1, 8'h4D, 33, 8'h4D, 0, 3'd3, 4'd1};

        rst_v = 2'b11; start_v = 2'b00; abort_v = 2'b00;
        tt_v[0] = GOLDEN; tt_v[1] = GOLDEN;
        repeat (3) @(negedge clk);
        rst_v = 2'b00;
        chk_en = 1'b1;
        for (int i = 0; i < 2; i++) begin
            checkOutput("reset_busy", i, 32'(busy_v[i]), 32'd0);
            checkOutput("reset_captured", i, 32'(cap_v[i]), 32'd0);
            checkOutput("reset_abc", i, 32'(abc_v[i]), 32'd0);
        end

        for (int v = 0; v < 8; v++) run_sweep(vecs[v]);

        // Abort mid-sweep after ignored start pulses.
        tt_v[0] = GOLDEN;
        applyStimulus(0, 0, 1, 0);
        t0 = cyc;
        applyStimulus(0, 0, 0, 0);
        applyStimulus(0, 0, 1, 0);
        applyStimulus(0, 0, 1, 0);
        checkOutput("abort_abc_v1", 0, 32'(abc_v[0]), 32'd1);
        applyStimulus(0, 0, 1, 0);
        applyStimulus(0, 0, 0, 1);
        checkOutput("abort_still_busy", 0, 32'(busy_v[0]), 32'd1);
        applyStimulus(0, 0, 0, 0);
        checkOutput("abort_delay", 0, 32'(cyc - t0), 32'd6);
        checkOutput("abort_busy", 0, 32'(busy_v[0]), 32'd0);
        checkOutput("abort_captured", 0, 32'(cap_v[0]), 32'h01);
        checkOutput("abort_pass", 0, 32'(pass_v[0]), 32'd0);
        saw_done = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (done_v[0]) saw_done = 1;
        end
        checkOutput("abort_no_done", 0, 32'(saw_done), 32'd0);

        // Abort coincident with the final sample.
        tt_v[0] = 8'hC5;
        applyStimulus(0, 0, 1, 0);
        for (int c = 0; c < 15; c++) applyStimulus(0, 0, 0, 0);
        applyStimulus(0, 0, 0, 1);
        applyStimulus(0, 0, 0, 0);
        checkOutput("final_abort_done", 0, 32'(done_v[0]), 32'd0);
        checkOutput("final_abort_busy", 0, 32'(busy_v[0]), 32'd0);
        checkOutput("final_abort_captured", 0, 32'(cap_v[0]), 32'h45);

        // Reset mid-sweep, then a fresh sweep.
        tt_v[0] = GOLDEN;
        applyStimulus(0, 0, 1, 0);
        for (int c = 0; c < 8; c++) applyStimulus(0, 0, 0, 0);
        applyStimulus(0, 1, 0, 0);
        checkOutput("pre_reset_captured", 0, 32'(cap_v[0]), 32'h05);
        applyStimulus(0, 0, 0, 0);
        checkOutput("mid_reset_busy", 0, 32'(busy_v[0]), 32'd0);
        checkOutput("mid_reset_abc", 0, 32'(abc_v[0]), 32'd0);
        checkOutput("mid_reset_captured", 0, 32'(cap_v[0]), 32'd0);
        run_sweep(vecs[0]);

        // Reset beats start; abort beats start in IDLE.
        applyStimulus(0, 1, 1, 0);
        applyStimulus(0, 0, 0, 0);
        checkOutput("rst_start_busy", 0, 32'(busy_v[0]), 32'd0);
        applyStimulus(0, 0, 1, 1);
        applyStimulus(0, 0, 0, 0);
        checkOutput("abort_start_busy", 0, 32'(busy_v[0]), 32'd0);

        // Randomized traffic on both instances, checked by the model every cycle.
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                rst_v[i]   = ($urandom_range(0, 299) == 0);
                start_v[i] = ($urandom_range(0, 5) == 0);
                abort_v[i] = ($urandom_range(0, 79) == 0);
                if ($urandom_range(0, 39) == 0) begin
                    case ($urandom_range(0, 3))
                        0, 1:    tt_v[i] = GOLDEN;
                        2:       tt_v[i] = GOLDEN ^ (8'd1 << $urandom_range(0, 7));
                        default: tt_v[i] = 8'($urandom);
                    endcase
                end
            end
        end
        @(negedge clk);
        rst_v = 2'b00; start_v = 2'b00; abort_v = 2'b00;
        repeat (40) @(negedge clk);
        chk_en = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
